// File: rtl/systolic_fir_engine.sv
// systolic_fir_engine: TAPS-point FIR over an unsigned, valid-qualified sample
// stream. The coefficients are signed and writable at runtime. Each result is
// computed at full precision, shifted right arithmetically, clamped to the
// output range and emitted with a fixed latency of 3 cycles after the sample
// that produced it was accepted.
module systolic_fir_engine #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_data,
  output logic                      sat_flag,
  output logic                      window_full
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam logic signed [ACC_W-1:0] MAX_OUT =
    $signed({{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}});

  logic        [DATA_W-1:0] win  [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PROD_W-1:0] prod [TAPS];
  logic        [AW-1:0]     fill_cnt;
  logic                     acc_v, prod_v, sum_v;
  logic                     wr_pend;
  logic        [AW-1:0]     wr_addr;
  logic signed [COEF_W-1:0] wr_data;
  logic signed [ACC_W-1:0]  sum_c, sum_q, shifted;
  logic        [OUT_W-1:0]  sat_val;
  logic                     clip;

  // Sample window, fill counter and the emit tag for the newly accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int k = 0; k < TAPS; k++) win[k] <= '0;
      fill_cnt    <= '0;
      window_full <= 1'b0;
      acc_v       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so that every window tap shifts
      // from its pre-edge neighbour, independent of statement order.
      acc_v <= in_valid && (window_full || fill_cnt == AW'(TAPS-1));
      if (in_valid) begin
        win[0] <= in_data;
        for (int k = 1; k < TAPS; k++) win[k] <= win[k-1];
        if (fill_cnt == AW'(TAPS-1)) window_full <= 1'b1;
        else                         fill_cnt    <= fill_cnt + 1'b1;
      end
    end
  end

  // Coefficient bank. A write is captured on its own edge and committed to the
  // bank one edge later. The product stage for a sample accepted on the write
  // edge therefore still reads the old set, and every later sample reads the
  // new one. Flush does not disturb this path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the coefficient bank is reset, unlike the datapath registers,
      // because reset must restore the identity filter.
      for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_W'(1) : '0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (wr_pend) coef[wr_addr] <= wr_data;
      wr_pend <= coef_we && (int'(coef_addr) < TAPS);
      wr_addr <= coef_addr;
      wr_data <= coef_data;
    end
  end

  // Stage 1: one signed product per tap. The sample is zero-extended so that
  // it stays non-negative.
  always_ff @(posedge clk) begin
    for (int k = 0; k < TAPS; k++)
      prod[k] <= coef[k] * $signed({1'b0, win[k]});
    prod_v <= rst_n && !flush && acc_v;
  end

  // Full-precision sum of all tap products.
  always_comb begin
    // NOTE: a default value comes first so that no path leaves sum_c unassigned
    // and a latch is never inferred.
    sum_c = '0;
    for (int k = 0; k < TAPS; k++) sum_c = sum_c + ACC_W'(prod[k]);
  end

  // Stage 2: register the adder-tree result.
  always_ff @(posedge clk) begin
    sum_q <= sum_c;
    sum_v <= rst_n && !flush && prod_v;
  end

  // Arithmetic shift, then clamp to the unsigned output range.
  always_comb begin
    shifted = sum_q >>> SHIFT;
    clip    = 1'b0;
    sat_val = shifted[OUT_W-1:0];
    if (shifted < 0) begin
      clip    = 1'b1;
      sat_val = '0;
    end else if (shifted > MAX_OUT) begin
      clip    = 1'b1;
      sat_val = '1;
    end
  end

  // Stage 3: output registers. Data and flag hold their value between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= sum_v && !flush;
      if (sum_v && !flush) begin
        out_data <= sat_val;
        sat_flag <= clip;
      end
    end
  end

endmodule

// File: tb/tb_systolic_fir_engine.sv
// Directed bench for systolic_fir_engine (default parameters). Every expected
// result is computed by hand and scheduled 3 cycles after its accept edge. On
// each cycle the bench checks out_valid against that schedule.
module tb_systolic_fir_engine;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, coef_we, flush;
  logic [7:0] in_data, coef_data, out_data;
  logic [2:0] coef_addr;
  logic       out_valid, sat_flag, window_full;

  typedef struct {
    int due;
    int data;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_on   = 1'b0;

  systolic_fir_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .sat_flag(sat_flag), .window_full(window_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge. The outputs are sampled 1 ns after the edge and compared
  // with the schedule.
  task automatic tick();
    bit exp_v;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_on) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_v) begin
        check("out_data", {24'd0, out_data}, exp_q[0].data);
        check("sat_flag", {31'd0, sat_flag}, {31'd0, exp_q[0].sat});
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] d, input bit emit, input int y, input bit s);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    if (emit) begin
      e.due  = cyc + 3;
      e.data = y;
      e.sat  = s;
      exp_q.push_back(e);
    end
  endtask

  task automatic wr(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 8'(val);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; flush = 1'b0;
    idle(2);
    rst_n = 1'b1;
    mon_on = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_sat_flag", {31'd0, sat_flag}, 0);
    check("rst_window_full", {31'd0, window_full}, 0);

    // All-ones taps. Eight 2s give 16, then a 1 enters the window and gives 15.
    for (int k = 0; k < 8; k++) wr(k, 1);
    for (int i = 0; i < 7; i++) send(8'd2, 1'b0, 0, 1'b0);
    check("wf_before_8th", {31'd0, window_full}, 0);
    send(8'd2, 1'b1, 16, 1'b0);
    check("wf_on_8th", {31'd0, window_full}, 1);
    send(8'd1, 1'b1, 15, 1'b0);
    idle(4);
    check("hold_out_data", {24'd0, out_data}, 15);

    // Identity taps after reset. The input gaps must show up as output gaps.
    do_reset();
    check("rst2_out_data", {24'd0, out_data}, 0);
    for (int n = 0; n <= 10; n++) begin
      send(8'(10 + n), n >= 7, 10 + n, 1'b0);
      idle(1);
    end
    idle(3);

    // Positive saturation: 8 * 127 * 255 clamps to 255.
    for (int k = 0; k < 8; k++) wr(k, 127);
    do_flush();
    for (int i = 0; i < 8; i++) send(8'd255, i == 7, 255, 1'b1);
    idle(4);

    // Negative saturation: -1 * 50 clamps to 0.
    wr(0, -1);
    for (int k = 1; k < 8; k++) wr(k, 0);
    do_flush();
    for (int i = 0; i < 8; i++) send(8'd50, i == 7, 0, 1'b1);
    idle(4);

    // A write in the same cycle as a sample applies only to later samples.
    for (int k = 0; k < 8; k++) wr(k, 1);
    do_flush();
    for (int i = 0; i < 8; i++) send(8'd5, i == 7, 40, 1'b0);
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd3;
    send(8'd5, 1'b1, 40, 1'b0);
    coef_we = 1'b0;
    send(8'd5, 1'b1, 50, 1'b0);
    idle(4);

    // Flush part-way through filling the window.
    wr(0, 1);
    do_flush();
    for (int i = 0; i < 5; i++) send(8'd9, 1'b0, 0, 1'b0);
    do_flush();
    check("wf_after_flush", {31'd0, window_full}, 0);
    for (int i = 0; i < 8; i++) send(8'd4, i == 7, 32, 1'b0);
    idle(4);

    // A reset 2 cycles after an accept drops that result and restores identity taps.
    send(8'd4, 1'b0, 0, 1'b0);
    idle(1);
    do_reset();
    check("rst3_window_full", {31'd0, window_full}, 0);
    check("rst3_out_data", {24'd0, out_data}, 0);
    idle(4);
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8, 8, 1'b0);
    idle(4);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
